calc_arbiter: RTL

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/calc_arbiter.sv
// calc_arbiter: two-requester round-robin front end for a shared multi-cycle
// calculator. A winner's operands are latched at grant. The calculator is then
// started, its result is captured, and the winner gets a one-cycle done pulse.
// Build option: define CALC_ARB_TIMEOUT_EN to bound the calculator wait with a
// TIMEOUT-cycle watchdog that reports err_o. Without it, err_o is tied low and
// the wait is unbounded.
module calc_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [1:0]           req_i,
    input  logic [WIDTH-1:0]     a0_i,
    input  logic [WIDTH-1:0]     b0_i,
    input  logic [1:0]           fct0_i,
    input  logic [WIDTH-1:0]     a1_i,
    input  logic [WIDTH-1:0]     b1_i,
    input  logic [1:0]           fct1_i,
    output logic [1:0]           gnt_o,
    output logic [1:0]           done_o,
    output logic                 err_o,
    output logic [2*WIDTH-1:0]   res_o,
    output logic [2*WIDTH-1:0]   rem_o,
    output logic                 calc_start_o,
    output logic [WIDTH-1:0]     calc_a_o,
    output logic [WIDTH-1:0]     calc_b_o,
    output logic [1:0]           calc_fct_o,
    input  logic                 calc_done_i,
    input  logic [2*WIDTH-1:0]   calc_res_i,
    input  logic [2*WIDTH-1:0]   calc_rem_i
);

    localparam int RW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       fct_q, fct_d;
    logic [RW-1:0]    res_q, res_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic             win_s;

`ifdef CALC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_s;

    // Watchdog expiry: this is the last WAIT cycle allowed before giving up.
    always_comb begin
        timeout_s = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
`else
    // TIMEOUT only shapes the watchdog variant; this empty check keeps it referenced.
    if (TIMEOUT < 1) begin : g_timeout_cfg_unused
    end
`endif

    // Round-robin winner: pointer side on contention, otherwise the lone requester.
    always_comb begin
        if (req_i == 2'b11) begin
            win_s = ptr_q;
        end else begin
            win_s = req_i[1];
        end
    end

    // Next-state and next-output logic for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        start_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        fct_d   = fct_q;
        res_d   = res_q;
        rem_d   = rem_q;
`ifdef CALC_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_d   = win_s ? 2'b10 : 2'b01;
                    ptr_d   = ~win_s;
                    a_d     = win_s ? a1_i   : a0_i;
                    b_d     = win_s ? b1_i   : b0_i;
                    fct_d   = win_s ? fct1_i : fct0_i;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
`ifdef CALC_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (calc_done_i) begin
                    res_d   = calc_res_i;
                    rem_d   = calc_rem_i;
                    done_d  = gnt_q;
                    state_d = RESP;
                end
`ifdef CALC_ARB_TIMEOUT_EN
                else if (timeout_s) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = WAIT;
                end
`else
                else begin
                    state_d = WAIT;
                end
`endif
            end
            RESP: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            fct_q   <= 2'b00;
            res_q   <= '0;
            rem_q   <= '0;
`ifdef CALC_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fct_q   <= fct_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
`ifdef CALC_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign calc_start_o = start_q;
    assign calc_a_o     = a_q;
    assign calc_b_o     = b_q;
    assign calc_fct_o   = fct_q;
    assign res_o        = res_q;
    assign rem_o        = rem_q;
`ifdef CALC_ARB_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule
